// File: rtl/seq_calculator.sv
// seq_calculator: start/done sequential ALU with shift-add multiply and optional restoring divide (SEQ_CALC_DIV_EN).
// Single-cycle ops finish one edge after acceptance; MUL/DIV iterate WIDTH edges.
module seq_calculator #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic [2:0]       op,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
  output logic             err,
  output logic             zero
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [2:0] OP_ADD = 3'd0, OP_SUB = 3'd1, OP_AND = 3'd2, OP_OR = 3'd3,
                         OP_XOR = 3'd4, OP_MUL = 3'd5, OP_DIV = 3'd6, OP_RES = 3'd7;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t           state;
  logic [WIDTH-1:0] a_r, b_r, ph, pl;
  logic [2:0]       op_r;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   add_s, sub_s, mul_sum;
  logic [WIDTH-1:0] mul_hi, mul_lo, div_hi, div_lo, lo_n, hi_n;
  logic             is_mul, is_div, iter, last, err_n;
  // ph/pl are shared: MUL keeps {partial product, multiplier}, DIV keeps {remainder, dividend/quotient}
  `ifdef SEQ_CALC_DIV_EN
  localparam bit DIV_EN = 1'b1;
  logic [WIDTH:0] div_sh, div_df;
  logic           div_ok;
  always_comb begin
    div_sh = {ph, pl[WIDTH-1]};
    div_df = div_sh - {1'b0, b_r};
    div_ok = !div_df[WIDTH];
    div_hi = div_ok ? div_df[WIDTH-1:0] : div_sh[WIDTH-1:0];
    div_lo = {pl[WIDTH-2:0], div_ok};
  end
  `else
  localparam bit DIV_EN = 1'b0;
  assign div_hi = '0;
  assign div_lo = '0;
  `endif
  always_comb begin
    add_s   = {1'b0, a_r} + {1'b0, b_r};
    sub_s   = {1'b0, a_r} - {1'b0, b_r};
    mul_sum = {1'b0, ph} + (pl[0] ? {1'b0, a_r} : '0);
    mul_hi  = mul_sum[WIDTH:1];
    mul_lo  = {mul_sum[0], pl[WIDTH-1:1]};
    is_mul  = op_r == OP_MUL;
    is_div  = DIV_EN && op_r == OP_DIV;
    iter    = is_mul || (is_div && b_r != '0);
    last    = !iter || cnt == LAST;
    lo_n    = op_r == OP_ADD ? add_s[WIDTH-1:0] :
              op_r == OP_SUB ? sub_s[WIDTH-1:0] :
              op_r == OP_AND ? a_r & b_r :
              op_r == OP_OR  ? a_r | b_r :
              op_r == OP_XOR ? a_r ^ b_r :
              is_mul         ? mul_lo :
              is_div         ? (b_r == '0 ? '1 : div_lo) : '0;
    hi_n    = op_r == OP_ADD ? {{(WIDTH-1){1'b0}}, add_s[WIDTH]} :
              op_r == OP_SUB ? {{(WIDTH-1){1'b0}}, sub_s[WIDTH]} :
              is_mul         ? mul_hi :
              is_div         ? (b_r == '0 ? a_r : div_hi) : '0;
    err_n   = op_r == OP_RES || (op_r == OP_DIV && !(is_div && b_r != '0));
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      result_lo <= '0;
      result_hi <= '0;
      err       <= 1'b0;
      zero      <= 1'b0;
      a_r       <= '0;
      b_r       <= '0;
      op_r      <= '0;
      ph        <= '0;
      pl        <= '0;
      cnt       <= '0;
    end else if (ena) begin
      case (state)
        IDLE, DONE: begin
          done  <= 1'b0;
          state <= IDLE;
          if (start) begin
            state <= CALC;
            busy  <= 1'b1;
            a_r   <= a_in;
            b_r   <= b_in;
            op_r  <= op;
            cnt   <= '0;
            ph    <= '0;
            pl    <= op == OP_MUL ? b_in : a_in;
          end
        end
        CALC: begin
          ph  <= is_mul ? mul_hi : div_hi;
          pl  <= is_mul ? mul_lo : div_lo;
          cnt <= cnt + 1'b1;
          if (last) begin
            state     <= DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
            result_lo <= lo_n;
            result_hi <= hi_n;
            err       <= err_n;
            zero      <= lo_n == '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_calculator.sv
// tb_seq_calculator: directed scoreboard bench for seq_calculator (WIDTH=8); expectations follow SEQ_CALC_DIV_EN.
module tb_seq_calculator;
  logic       clk = 1'b0, rst_n = 1'b0, ena = 1'b1, start = 1'b0;
  logic [7:0] a_in = '0, b_in = '0;
  logic [2:0] op = '0;
  logic       busy, done, err, zero;
  logic [7:0] result_lo, result_hi;
  typedef struct {
    logic [7:0] lo, hi;
    logic       err, zero;
    int         k, lat;
  } exp_t;
  exp_t q[$];
  exp_t e;
  int   cyc = 0, compared = 0, mismatched = 0;
  logic prev_done = 1'b0;
  seq_calculator #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .a_in(a_in), .b_in(b_in), .op(op), .start(start),
    .busy(busy), .done(done), .result_lo(result_lo), .result_hi(result_hi), .err(err), .zero(zero)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask
  // monitor: pop one expectation per done pulse (a done held by ena=0 counts once)
  always @(negedge clk) begin
    chk("busy_done_exclusive", int'(busy & done), 0);
    if (done && !prev_done) begin
      if (q.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_done: got done=1 expected no pending op at cycle %0d", cyc);
      end else begin
        e = q.pop_front();
        chk("result_lo", int'(result_lo), int'(e.lo));
        chk("result_hi", int'(result_hi), int'(e.hi));
        chk("err", int'(err), int'(e.err));
        chk("zero", int'(zero), int'(e.zero));
        chk("latency", cyc - e.k, e.lat);
      end
    end
    prev_done = done;
  end
  task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic [2:0] o,
                       input logic [7:0] lo, input logic [7:0] hi, input logic er, input int lat);
    exp_t x;
    a_in = a; b_in = b; op = o; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    x.lo = lo; x.hi = hi; x.err = er; x.zero = (lo == 8'h00); x.k = cyc; x.lat = lat;
    q.push_back(x);
  endtask
  task automatic wait_idle();
    for (int i = 0; i < 60 && q.size() != 0; i++) @(negedge clk);
    if (q.size() != 0) begin
      compared++;
      mismatched++;
      $display("FAIL timeout: got %0d pending ops expected 0", q.size());
      q.delete();
    end
    @(negedge clk);
  endtask
  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_lo"}, int'(result_lo), 0);
    chk({tag, "_hi"}, int'(result_hi), 0);
    chk({tag, "_err"}, int'(err), 0);
    chk({tag, "_zero"}, int'(zero), 0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1, "watchdog");
  end
  initial begin
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);
    issue(8'd200, 8'd100, 3'd0, 8'h2C, 8'h01, 1'b0, 1);
    wait_idle();
    issue(8'd5, 8'd7, 3'd1, 8'hFE, 8'h01, 1'b0, 1);
    @(negedge clk);
    chk("sub_done_pulse", int'(done), 1);
    issue(8'h5A, 8'h5A, 3'd4, 8'h00, 8'h00, 1'b0, 1);
    chk("b2b_busy", int'(busy), 1);
    chk("b2b_done_low", int'(done), 0);
    wait_idle();
    issue(8'd255, 8'd255, 3'd5, 8'h01, 8'hFE, 1'b0, 8);
    chk("mul_busy", int'(busy), 1);
    @(negedge clk);
    a_in = 8'h12; b_in = 8'h34; op = 3'd0;
    repeat (2) @(negedge clk);
    a_in = 8'h00;
    wait_idle();
    issue(8'hF0, 8'h3C, 3'd2, 8'h30, 8'h00, 1'b0, 1);
    wait_idle();
    issue(8'hF0, 8'h0F, 3'd3, 8'hFF, 8'h00, 1'b0, 1);
    wait_idle();
    issue(8'd33, 8'd44, 3'd7, 8'h00, 8'h00, 1'b1, 1);
    wait_idle();
`ifdef SEQ_CALC_DIV_EN
    issue(8'd100, 8'd7, 3'd6, 8'd14, 8'd2, 1'b0, 8);
    wait_idle();
    issue(8'd9, 8'd0, 3'd6, 8'hFF, 8'd9, 1'b1, 1);
    wait_idle();
    issue(8'd100, 8'd7, 3'd6, 8'd14, 8'd2, 1'b0, 13);
`else
    issue(8'd100, 8'd7, 3'd6, 8'h00, 8'h00, 1'b1, 1);
    wait_idle();
    issue(8'd9, 8'd0, 3'd6, 8'h00, 8'h00, 1'b1, 1);
    wait_idle();
    issue(8'd12, 8'd13, 3'd5, 8'h9C, 8'h00, 1'b0, 13);
`endif
    repeat (2) @(negedge clk);
    ena = 1'b0;
    repeat (5) @(negedge clk);
    chk("ena_hold_busy", int'(busy), 1);
    ena = 1'b1;
    @(negedge clk);
    a_in = 8'd1; b_in = 8'd1; op = 3'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle();
    repeat (3) @(negedge clk);
    issue(8'd3, 8'd4, 3'd0, 8'd7, 8'd0, 1'b0, 1);
    @(negedge clk);
    chk("done_pulse", int'(done), 1);
    ena = 1'b0;
    repeat (2) @(negedge clk);
    chk("done_held_ena0", int'(done), 1);
    ena = 1'b1;
    @(negedge clk);
    chk("done_released", int'(done), 0);
    issue(8'd255, 8'd255, 3'd5, 8'h01, 8'hFE, 1'b0, 8);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_all_zero("midmul_reset");
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    issue(8'd1, 8'd1, 3'd0, 8'd2, 8'd0, 1'b0, 1);
    wait_idle();
    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
